// File: rtl/controller_hub_pkg.sv
// Shared definitions for the serial game-controller hub: FSM state
// encoding, counter-width helpers and the frame-length formula.
package controller_hub_pkg;

    // Sequencer states; encoding is fixed so state dumps stay readable.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_CLK_HIGH = 3'd2,
        ST_CLK_LOW  = 3'd3,
        ST_DONE     = 3'd4
    } hub_state_e;

    // Phase counter must reach 2*HALF_PERIOD-1, the longest phase (latch).
    function automatic int phase_cnt_width(input int half_period);
        return $clog2(2 * half_period);
    endfunction

    // Bit counter indexes buttons 0..BUTTONS-1.
    function automatic int bit_cnt_width(input int buttons);
        return (buttons > 1) ? $clog2(buttons) : 1;
    endfunction

    // Cycles from the start_fetch cycle to the frame_valid cycle.
    function automatic int frame_len(input int half_period, input int buttons);
        return 2 * half_period * buttons + 1;
    endfunction

endpackage

// File: rtl/controller_hub_m_channel.sv
// One pad channel: input synchroniser, shift register, committed button
// levels and sticky newly-pressed flags.
module controller_channel_m #(
    parameter int BUTTONS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pad_data_n,
    input  logic               sample_strobe,
    input  logic               commit_strobe,
    input  logic               clear,
    output logic [BUTTONS-1:0] buttons,
    output logic [BUTTONS-1:0] pressed
);

    logic               sync1_reg;
    logic               sync2_reg;
    logic [BUTTONS-1:0] shift_reg;
    logic [BUTTONS-1:0] buttons_reg;
    logic [BUTTONS-1:0] pressed_reg;
    logic               pad_bit;
    logic [BUTTONS-1:0] pressed_next;

    // Pad data is asynchronous to our clock and active-low.
    assign pad_bit = ~sync2_reg;

    // Two-flop synchroniser on the raw pad line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pad_data_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Shift right so that after BUTTONS samples the first bit sits in bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (sample_strobe) begin
            shift_reg <= {pad_bit, shift_reg[BUTTONS-1:1]};
        end
    end

    // On commit a new press wins over a simultaneous clear; otherwise clear wipes.
    always_comb begin
        pressed_next = pressed_reg;
        if (commit_strobe) begin
            pressed_next = (pressed_reg & ~{BUTTONS{clear}}) | (shift_reg & ~buttons_reg);
        end else if (clear) begin
            pressed_next = '0;
        end
    end

    // Committed button levels and sticky press flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buttons_reg <= '0;
            pressed_reg <= '0;
        end else begin
            if (commit_strobe) begin
                buttons_reg <= shift_reg;
            end
            pressed_reg <= pressed_next;
        end
    end

    assign buttons = buttons_reg;
    assign pressed = pressed_reg;

endmodule

// File: rtl/controller_hub_m.sv
// Controller hub top: latch/clock sequencer shared by all pads, phase and
// bit counters, and registered pad-facing outputs. Per-pad state lives in
// controller_channel_m instances.
module controller_hub_m
    import controller_hub_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int BUTTONS         = 8,
    parameter int HALF_PERIOD     = 63
) (
    input  logic                               clk_12_5875,
    input  logic                               rst,
    input  logic                               start_fetch,
    input  logic [NUM_CONTROLLERS-1:0]         clear_pressed,
    input  logic [NUM_CONTROLLERS-1:0]         data_in_B,
    output logic                               controller_latch,
    output logic                               controller_clk,
    output logic                               busy,
    output logic                               frame_valid,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed_out
);

    localparam int PW = phase_cnt_width(HALF_PERIOD);
    localparam int BW = bit_cnt_width(BUTTONS);

    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [BW:0]   LAST_BIT   = (BW + 1)'(BUTTONS - 1);

    hub_state_e    state_reg;
    hub_state_e    state_next;
    logic [PW-1:0] phase_cnt_reg;
    logic [PW-1:0] phase_cnt_next;
    logic [BW-1:0] bit_cnt_reg;
    logic [BW-1:0] bit_cnt_next;
    logic [BW:0]   bit_inc;
    logic          sample_strobe;
    logic          commit_strobe;
    logic          latch_reg;
    logic          clk_out_reg;
    logic          busy_reg;
    logic          frame_valid_reg;

    // Sequencer: latch pulse, then BUTTONS-1 clock pulses, then one commit cycle.
    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        sample_strobe  = 1'b0;
        commit_strobe  = 1'b0;
        bit_inc        = {1'b0, bit_cnt_reg} + (BW + 1)'(1);
        case (state_reg)
            ST_IDLE: begin
                if (start_fetch) begin
                    state_next     = ST_LATCH;
                    phase_cnt_next = '0;
                    bit_cnt_next   = '0;
                end
            end
            ST_LATCH: begin
                if (phase_cnt_reg == LATCH_LAST) begin
                    sample_strobe  = 1'b1;
                    state_next     = ST_CLK_HIGH;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PW'(1);
                end
            end
            ST_CLK_HIGH: begin
                if (phase_cnt_reg == HALF_LAST) begin
                    state_next     = ST_CLK_LOW;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PW'(1);
                end
            end
            ST_CLK_LOW: begin
                if (phase_cnt_reg == HALF_LAST) begin
                    sample_strobe  = 1'b1;
                    bit_cnt_next   = bit_inc[BW-1:0];
                    phase_cnt_next = '0;
                    state_next     = (bit_inc < LAST_BIT) ? ST_CLK_HIGH : ST_DONE;
                end else begin
                    phase_cnt_next = phase_cnt_reg + PW'(1);
                end
            end
            ST_DONE: begin
                commit_strobe = 1'b1;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and counters; reset aborts any frame in progress.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            phase_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
        end
    end

    // Outputs registered from the next state so they are glitch-free and
    // line up exactly with the state they describe.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            latch_reg       <= 1'b0;
            clk_out_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            latch_reg       <= (state_next == ST_LATCH);
            clk_out_reg     <= (state_next == ST_CLK_HIGH);
            busy_reg        <= (state_next != ST_IDLE);
            frame_valid_reg <= (state_next == ST_DONE);
        end
    end

    assign controller_latch = latch_reg;
    assign controller_clk   = clk_out_reg;
    assign busy             = busy_reg;
    assign frame_valid      = frame_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_channel
            controller_channel_m #(
                .BUTTONS(BUTTONS)
            ) u_channel (
                .clk          (clk_12_5875),
                .rst          (rst),
                .pad_data_n   (data_in_B[gi]),
                .sample_strobe(sample_strobe),
                .commit_strobe(commit_strobe),
                .clear        (clear_pressed[gi]),
                .buttons      (buttons_out[gi*BUTTONS +: BUTTONS]),
                .pressed      (pressed_out[gi*BUTTONS +: BUTTONS])
            );
        end
    endgenerate

endmodule

// File: tb/tb_controller_hub_m.sv
// Bench for controller_hub_m: two configurations (2x8 H=4, 4x12 H=5) driven
// by behavioural shift-register pads, checked against a frame-level model.
module tb_controller_hub_m;
    import controller_hub_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  clear_a = '0;
    logic [3:0]  clear_b = '0;
    logic [1:0]  din_a = '1;
    logic [3:0]  din_b = '1;
    logic        a_latch, a_cclk, a_busy, a_fv;
    logic        b_latch, b_cclk, b_busy, b_fv;
    logic [15:0] a_buttons, a_pressed;
    logic [47:0] b_buttons, b_pressed;

    controller_hub_m #(.NUM_CONTROLLERS(2), .BUTTONS(8), .HALF_PERIOD(4)) dut_a (
        .clk_12_5875(clk), .rst(rst), .start_fetch(start_a), .clear_pressed(clear_a),
        .data_in_B(din_a), .controller_latch(a_latch), .controller_clk(a_cclk),
        .busy(a_busy), .frame_valid(a_fv), .buttons_out(a_buttons), .pressed_out(a_pressed));

    controller_hub_m #(.NUM_CONTROLLERS(4), .BUTTONS(12), .HALF_PERIOD(5)) dut_b (
        .clk_12_5875(clk), .rst(rst), .start_fetch(start_b), .clear_pressed(clear_b),
        .data_in_B(din_b), .controller_latch(b_latch), .controller_clk(b_cclk),
        .busy(b_busy), .frame_valid(b_fv), .buttons_out(b_buttons), .pressed_out(b_pressed));

    always #5 clk = ~clk;

    // Behavioural pads: load on latch, shift on each rising pad clock,
    // drive the current bit active-low.
    logic [15:0] pad_a = '0;
    logic [47:0] pad_b = '0;
    logic [7:0]  sr_a [2] = '{default: '0};
    logic [11:0] sr_b [4] = '{default: '0};
    logic        prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (a_latch) sr_a[i] = pad_a[i*8 +: 8];
            else if (a_cclk && !prev_a) sr_a[i] = sr_a[i] >> 1;
            din_a[i] = ~sr_a[i][0];
        end
        prev_a = a_cclk;
        for (int i = 0; i < 4; i++) begin
            if (b_latch) sr_b[i] = pad_b[i*12 +: 12];
            else if (b_cclk && !prev_b) sr_b[i] = sr_b[i] >> 1;
            din_b[i] = ~sr_b[i][0];
        end
        prev_b = b_cclk;
    end

    // Selected-configuration view used by the generic tasks.
    bit          sel = 1'b0;
    logic        m_latch, m_cclk, m_busy, m_fv;
    logic [47:0] m_buttons, m_pressed;

    always_comb begin
        m_latch   = sel ? b_latch : a_latch;
        m_cclk    = sel ? b_cclk : a_cclk;
        m_busy    = sel ? b_busy : a_busy;
        m_fv      = sel ? b_fv : a_fv;
        m_buttons = sel ? b_buttons : {32'd0, a_buttons};
        m_pressed = sel ? b_pressed : {32'd0, a_pressed};
    end

    // Reference model: committed levels and sticky presses per configuration.
    logic [47:0] exp_btn [2] = '{default: '0};
    logic [47:0] exp_pr  [2] = '{default: '0};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cfg=%0d got=%h exp=%h", tag, sel, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_clear(input logic [3:0] m);
        if (sel) clear_b = m; else clear_a = m[1:0];
    endtask

    function automatic logic [47:0] expand(input logic [3:0] m, input int nc, input int nb);
        logic [47:0] r = '0;
        for (int i = 0; i < nc; i++)
            for (int j = 0; j < nb; j++)
                r[i*nb + j] = m[i];
        return r;
    endfunction

    // One complete frame: present pads, pulse start_fetch, measure the
    // pad-side waveform, optionally clear during the frame_valid cycle.
    task automatic run_frame(input logic [47:0] pads, input logic [3:0] clr_done, input bit reject);
        int nb, hp, nc, cyc, n_latch, n_high, n_pulse, flen;
        logic prev_c;
        logic [47:0] act_mask, newv;
        bit done, timed_out;
        nb = sel ? 12 : 8;
        hp = sel ? 5 : 4;
        nc = sel ? 4 : 2;
        act_mask = (48'd1 << (nc*nb)) - 48'd1;
        newv = pads & act_mask;
        if (sel) pad_b = newv; else pad_a = newv[15:0];
        flen = frame_len(hp, nb);
        @(posedge clk); #1;
        set_start(1'b1);
        cyc = 0; n_latch = 0; n_high = 0; n_pulse = 0;
        prev_c = 1'b0; done = 1'b0; timed_out = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            set_start(reject && (cyc == 10 || cyc == 64));
            if (m_latch) n_latch++;
            if (m_cclk) n_high++;
            if (m_cclk && !prev_c) n_pulse++;
            prev_c = m_cclk;
            if (m_fv) done = 1'b1;
            else if (cyc > flen + 20) begin done = 1'b1; timed_out = 1'b1; end
        end
        if (timed_out) begin
            check_eq("frame_timeout", 48'(cyc), 48'(flen));
            set_start(1'b0);
            return;
        end
        check_eq("frame_len", 48'(cyc), 48'(flen));
        check_eq("latch_cycles", 48'(n_latch), 48'(2*hp));
        check_eq("clk_pulses", 48'(n_pulse), 48'(nb-1));
        check_eq("clk_high_cycles", 48'(n_high), 48'((nb-1)*hp));
        check_eq("busy_in_done", 48'(m_busy), 48'd1);
        set_clear(clr_done);
        exp_pr[sel]  = (exp_pr[sel] & ~expand(clr_done, nc, nb)) | (newv & ~exp_btn[sel]);
        exp_btn[sel] = newv;
        @(posedge clk); #1;
        set_clear(4'd0);
        check_eq("fv_pulse_end", 48'(m_fv), 48'd0);
        check_eq("busy_after", 48'(m_busy), 48'd0);
        check_eq("buttons", m_buttons, exp_btn[sel]);
        check_eq("pressed", m_pressed, exp_pr[sel]);
        $display("frame cfg=%0d pads=%h clr=%h buttons=%h pressed=%h", sel, newv, clr_done, m_buttons, m_pressed);
    endtask

    initial begin
        logic acc;
        int fv_cnt;
        logic [47:0] rp;

        // Reset state of both configurations.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            check_eq("rst_outputs", {m_buttons | m_pressed}, 48'd0);
            check_eq("rst_ctrl", 48'({m_latch, m_cclk, m_busy, m_fv}), 48'd0);
        end
        sel = 1'b0;
        rst = 1'b0;

        // Quiet idle: nothing may move without start_fetch.
        acc = 1'b0;
        repeat (1000) begin
            @(posedge clk); #1;
            acc = acc | a_latch | a_cclk | a_busy | a_fv | (|a_buttons) | (|a_pressed)
                      | b_latch | b_cclk | b_busy | b_fv | (|b_buttons) | (|b_pressed);
        end
        check_eq("idle_quiet", 48'(acc), 48'd0);

        // Basic frame with busy-time start_fetch re-pulses that must be dropped.
        run_frame(48'h0000_0000_0009, 4'd0, 1'b1);
        fv_cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (a_fv) fv_cnt++;
        end
        check_eq("reject_no_extra_frame", 48'(fv_cnt), 48'd0);

        // Edge detection across frames.
        run_frame(48'h0000_0000_0001, 4'd0, 1'b0);
        run_frame(48'h0000_0000_0081, 4'd0, 1'b0);
        // Clear collides with a new Right press: set wins.
        run_frame(48'h0000_0000_0001, 4'd0, 1'b0);
        run_frame(48'h0000_0000_0081, 4'b0001, 1'b0);
        // Clear while idle.
        @(posedge clk); #1;
        set_clear(4'b0001);
        exp_pr[0] = exp_pr[0] & ~expand(4'b0001, 2, 8);
        @(posedge clk); #1;
        set_clear(4'd0);
        check_eq("idle_clear", m_pressed, exp_pr[0]);

        // Randomised frames on the 2x8 configuration.
        for (int f = 0; f < 6; f++) begin
            rp = {$urandom, $urandom};
            run_frame(rp, 4'($urandom_range(0, 3)), 1'b0);
        end

        // 4x12 configuration: abort a frame with reset at cycle 30.
        sel = 1'b1;
        pad_b = 48'hFFF_FFF_FFF_FFF;
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_outputs", b_buttons | b_pressed, 48'd0);
        check_eq("abort_ctrl", 48'({b_latch, b_cclk, b_busy, b_fv}), 48'd0);
        exp_btn[0] = '0; exp_pr[0] = '0;
        exp_btn[1] = '0; exp_pr[1] = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int f = 0; f < 5; f++) begin
            rp = {$urandom, $urandom};
            run_frame(rp, 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controller_hub_m.md
# controller_hub_m

Parametrised serial game-controller reader, successor to the fixed two-pad, eight-button controller interface. It generates latch and clock for NUM_CONTROLLERS shift-register pads from the 12.5875 MHz system clock, with no separate slow clock or enable. Every start_fetch pulse from the GPU captures one frame of button state. Per controller it keeps a level register and a sticky "newly pressed" register for the CPU-side address decoder.

## Interface
- NUM_CONTROLLERS, 2, number of pads; ≥1
- BUTTONS, 8, bits shifted per pad (8 = NES, 12/16 = SNES); ≥2
- HALF_PERIOD, 63, system-clock cycles per controller-clock half period (≈99.9 kHz at 12.5875 MHz); ≥4

- clk_12_5875  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_fetch  in  1  one-cycle request to sample all pads (GPU, start of vblank)
- clear_pressed  in  NUM_CONTROLLERS  bit i clears controller i's pressed register
- data_in_B  in  NUM_CONTROLLERS  serial pad data, active-low (0 = pressed)
- controller_latch  out  1  registered latch to pads, active-high
- controller_clk  out  1  registered shift clock to pads, idle low
- busy  out  1  high whenever the FSM is not in IDLE
- frame_valid  out  1  one-cycle pulse when new buttons_out is committed
- buttons_out  out  NUM_CONTROLLERS*BUTTONS  slice [i*BUTTONS +: BUTTONS] is pad i, 1 = pressed
- pressed_out  out  NUM_CONTROLLERS*BUTTONS  sticky 0→1 transitions, same slicing

## Operation
- data_in_B passes through a 2-flop synchroniser per channel and is inverted before use.
- FSM states: IDLE, LATCH, CLK_HIGH, CLK_LOW, DONE. One phase counter, width $clog2(2*HALF_PERIOD), and one bit counter, width $clog2(BUTTONS).
- IDLE → LATCH when start_fetch=1. Bit counter = 0.
- LATCH: controller_latch=1 for 2*HALF_PERIOD cycles. On the last cycle, bit 0 of every channel is sampled from the synchronised input.
- LATCH → CLK_HIGH. controller_clk=1 for HALF_PERIOD cycles.
- CLK_HIGH → CLK_LOW. controller_clk=0 for HALF_PERIOD cycles. On the last cycle, bit k (k = bit counter + 1) is sampled and the bit counter increments.
- CLK_LOW → CLK_HIGH while k < BUTTONS-1. Otherwise CLK_LOW → DONE.
- The first bit shifted in lands in bit 0 (NES order: A, B, Select, Start, Up, Down, Left, Right).
- DONE, one cycle:
  - buttons_out ← new sample
  - pressed_next = (pressed & ~{BUTTONS{clear_pressed[i]}}) | (new & ~old buttons)
  - frame_valid=1
  - → IDLE
- clear_pressed is honoured in every state. A clear and a new press on the same bit in the DONE cycle leave the bit set (set wins).
- start_fetch while busy=1 is ignored and not queued.
- Channels are sampled in lockstep; all pads share the latch and clock.

## Timing
- Reset values: controller_latch=0, controller_clk=0, busy=0, frame_valid=0, buttons_out=0, pressed_out=0, synchronisers=0, FSM=IDLE.
- Asserting rst mid-frame aborts the frame immediately. Outputs go to reset values and the partial sample is discarded.
- controller_latch rises one cycle after start_fetch is sampled high. busy rises on the same edge.
- Sequence length from the accepting edge to the frame_valid pulse: 2*HALF_PERIOD*BUTTONS + 1 cycles. busy falls on the edge after frame_valid.
- Number of controller_clk pulses per frame: BUTTONS-1, each HALF_PERIOD cycles high.
- Input sampling point: the last cycle of each low or latch phase, using 2-cycle-delayed pad data. The pad needs data valid ≥ HALF_PERIOD-3 cycles after its rising clock.
- buttons_out and pressed_out change only in DONE (or on a clear), never mid-shift.

## Structure
- Package controller_hub_pkg holds:
  - the FSM state enum
  - localparam helpers for counter widths
  - the frame-length function 2*H*B+1, shared by RTL and bench
- Sub-module controller_channel_m, generated NUM_CONTROLLERS times. It contains the synchroniser, shift register, buttons register and pressed register. Its inputs are sample strobe, commit strobe and clear.
- The top contains the FSM, counters and output registers only.

## Test plan
- Reset/idle: hold rst, then release with no start_fetch for 1000 cycles → all outputs stay 0, busy=0.
- Basic frame (N=2, B=8, H=4): pad0 serial pattern A+Start (8'b0000_1001), pad1 none → frame_valid at cycle 65, buttons_out=16'h0009, pressed_out=16'h0009, 7 clock pulses, latch high 8 cycles.
- Edge detect: second frame with pad0 = A only, then third with A+Right → pressed_out stays 16'h0009 after frame 2 and becomes 16'h0089 after frame 3.
- Clear vs set collision: clear_pressed=2'b01 held through the DONE cycle while Right newly pressed → pressed_out[7:0]=8'h80. A clear on an idle cycle → pressed_out[7:0]=8'h00.
- Busy rejection: start_fetch re-pulsed at cycles 10 and 64 → exactly one frame, frame_valid once, next frame only after a new pulse in IDLE.
- Reset mid-frame, then generic config (N=4, B=12, H=5): rst at cycle 30 → outputs 0 immediately. Then a full frame completes in 121 cycles with all four slices correct.
